wb_replay_unit: RTL and testbench

WB_REPLAY_UNIT -- requirements
Module: wb_replay_unit

---
 rtl/wb_replay_unit_pkg.sv | 18 +
 rtl/wb_replay_unit_fifo.sv | 42 ++++
 rtl/wb_replay_unit.sv | 116 +++++++++++
 tb/tb_wb_replay_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_replay_unit_pkg.sv
// wb_replay_unit_pkg: shared entry struct, FSM enum and entry field widths for the replay unit
// Entry fields are sized by the E_* localparams; the top's width parameters must not exceed them.
package wb_replay_unit_pkg;
  localparam int E_ADDR = 32;
  localparam int E_DATA = 32;
  localparam int E_MOP  = 5;
  localparam int E_DEST = 6;
  localparam int E_TKT  = 3;
  typedef struct packed {
    logic              is_store;
    logic [E_ADDR-1:0] addr;
    logic [E_DATA-1:0] data;
    logic [E_MOP-1:0]  microop;
    logic [E_DEST-1:0] dest;
    logic [E_TKT-1:0]  ticket;
  } replay_entry_t;
  typedef enum logic [1:0] {IDLE, LOOKUP, WALK, DRAIN} replay_state_t;
endpackage

// File: rtl/wb_replay_unit_fifo.sv
// replay_fifo: power-of-two FIFO of replay entries with combinational head
// ports: clk, rst_n (async, active-low), push/din write side, pop/head read side, empty flag
module replay_fifo
  import wb_replay_unit_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter type entry_t = replay_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t din,
  input  logic   pop,
  output entry_t head,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic full, do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  // a push into a full queue is only honoured if the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign head = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // payload storage carries no reset
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
endmodule

// File: rtl/wb_replay_unit.sv
// wb_replay_unit: after a refill, walks the wait buffer and replays matching loads/stores in order
// ports: clk, rst_n (async, active-low); refill_valid/ready/addr refill handshake;
//   wb_search_* wait-buffer search/walk interface; ld_* load replay port; st_* store replay port;
//   busy; perf_ld_cnt/perf_st_cnt only when WB_REPLAY_PERF_EN is defined.
module wb_replay_unit
  import wb_replay_unit_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_BITS      = 32,
  parameter int BLOCK_ID_START = 5,
  parameter int R_WIDTH        = 6,
  parameter int MICROOP        = 5,
  parameter int ROB_TICKET     = 3,
  parameter int RQ_DEPTH       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  refill_valid,
  output logic                  refill_ready,
  input  logic [ADDR_BITS-1:0]  refill_addr,
  output logic [ADDR_BITS-1:0]  wb_search_address,
  output logic                  wb_search_invalidate,
  input  logic                  wb_search_found_one,
  input  logic                  wb_search_found_multi,
  input  logic                  wb_in_walk_mode,
  input  logic                  wb_search_is_store,
  input  logic [ADDR_BITS-1:0]  wb_search_address_o,
  input  logic [DATA_WIDTH-1:0] wb_search_data,
  input  logic [MICROOP-1:0]    wb_search_microop,
  input  logic [R_WIDTH-1:0]    wb_search_dest,
  input  logic [ROB_TICKET-1:0] wb_search_ticket,
  output logic                  ld_valid,
  input  logic                  ld_ready,
  output logic [ADDR_BITS-1:0]  ld_addr,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic [MICROOP-1:0]    ld_microop,
  output logic [R_WIDTH-1:0]    ld_dest,
  output logic [ROB_TICKET-1:0] ld_ticket,
  output logic                  st_valid,
  input  logic                  st_ready,
  output logic [ADDR_BITS-1:0]  st_addr,
  output logic [DATA_WIDTH-1:0] st_data,
  output logic [MICROOP-1:0]    st_microop,
  output logic                  busy
`ifdef WB_REPLAY_PERF_EN
  ,
  output logic [31:0]           perf_ld_cnt,
  output logic [31:0]           perf_st_cnt
`endif
);
  replay_state_t state, state_n;
  logic [ADDR_BITS-1:0] blk_addr;
  logic match, push, pop, empty;
  replay_entry_t din, head;
  assign match = wb_search_address_o[ADDR_BITS-1:BLOCK_ID_START] == blk_addr[ADDR_BITS-1:BLOCK_ID_START];
  assign push = state == WALK && wb_in_walk_mode && match;
  assign ld_valid = !empty && !head.is_store;
  assign st_valid = !empty && head.is_store;
  assign pop = (ld_valid && ld_ready) || (st_valid && st_ready);
  assign refill_ready = state == IDLE && empty;
  assign busy = state != IDLE || !empty;
  assign wb_search_address = (state == LOOKUP || state == WALK) ? blk_addr : '0;
  assign wb_search_invalidate = state == LOOKUP && wb_search_found_one;
  assign ld_addr = ADDR_BITS'(head.addr);
  assign ld_data = DATA_WIDTH'(head.data);
  assign ld_microop = MICROOP'(head.microop);
  assign ld_dest = R_WIDTH'(head.dest);
  assign ld_ticket = ROB_TICKET'(head.ticket);
  assign st_addr = ADDR_BITS'(head.addr);
  assign st_data = DATA_WIDTH'(head.data);
  assign st_microop = MICROOP'(head.microop);
  always_comb begin
    din.is_store = wb_search_is_store;
    din.addr = E_ADDR'(wb_search_address_o);
    din.data = E_DATA'(wb_search_data);
    din.microop = E_MOP'(wb_search_microop);
    din.dest = E_DEST'(wb_search_dest);
    din.ticket = E_TKT'(wb_search_ticket);
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (refill_valid && refill_ready) state_n = LOOKUP;
      LOOKUP:  state_n = wb_search_found_one ? WALK : DRAIN;
      WALK:    if (wb_in_walk_mode && !wb_search_found_multi) state_n = DRAIN;
      default: if (empty) state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      blk_addr <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && refill_valid && refill_ready) blk_addr <= refill_addr;
    end
  replay_fifo #(.DEPTH(RQ_DEPTH), .entry_t(replay_entry_t)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .empty (empty)
  );
`ifdef WB_REPLAY_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_ld_cnt <= '0;
      perf_st_cnt <= '0;
    end else begin
      if (ld_valid && ld_ready && perf_ld_cnt != '1) perf_ld_cnt <= perf_ld_cnt + 32'd1;
      if (st_valid && st_ready && perf_st_cnt != '1) perf_st_cnt <= perf_st_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_wb_replay_unit.sv
// tb_wb_replay_unit: directed bench for wb_replay_unit with a queue-based reference model
module tb_wb_replay_unit;
  logic clk = 0, rst_n = 0;
  logic refill_valid = 0, refill_ready;
  logic [31:0] refill_addr = 0, wb_search_address;
  logic wb_search_invalidate;
  logic wb_search_found_one = 0, wb_search_found_multi = 0, wb_in_walk_mode = 0, wb_search_is_store = 0;
  logic [31:0] wb_search_address_o = 0, wb_search_data = 0;
  logic [4:0] wb_search_microop = 0;
  logic [5:0] wb_search_dest = 0;
  logic [2:0] wb_search_ticket = 0;
  logic ld_valid, ld_ready = 0, st_valid, st_ready = 0, busy;
  logic [31:0] ld_addr, ld_data, st_addr, st_data;
  logic [4:0] ld_microop, st_microop;
  logic [5:0] ld_dest;
  logic [2:0] ld_ticket;
`ifdef WB_REPLAY_PERF_EN
  logic [31:0] perf_ld_cnt, perf_st_cnt;
`endif

  wb_replay_unit dut (
    .clk(clk), .rst_n(rst_n),
    .refill_valid(refill_valid), .refill_ready(refill_ready), .refill_addr(refill_addr),
    .wb_search_address(wb_search_address), .wb_search_invalidate(wb_search_invalidate),
    .wb_search_found_one(wb_search_found_one), .wb_search_found_multi(wb_search_found_multi),
    .wb_in_walk_mode(wb_in_walk_mode), .wb_search_is_store(wb_search_is_store),
    .wb_search_address_o(wb_search_address_o), .wb_search_data(wb_search_data),
    .wb_search_microop(wb_search_microop), .wb_search_dest(wb_search_dest),
    .wb_search_ticket(wb_search_ticket),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_microop(ld_microop), .ld_dest(ld_dest), .ld_ticket(ld_ticket),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .st_microop(st_microop), .busy(busy)
`ifdef WB_REPLAY_PERF_EN
    , .perf_ld_cnt(perf_ld_cnt), .perf_st_cnt(perf_st_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // reference model: phase 0 idle, 1 lookup, 2 walk, 3 drain; pending replays held in a queue
  typedef struct {
    bit          s;
    logic [31:0] a, d;
    logic [4:0]  mo;
    logic [5:0]  de;
    logic [2:0]  tk;
  } ent_t;
  ent_t mq[$];
  ent_t m_e;
  int ms, m_nxt;
  logic [31:0] m_addr;
  bit m_pop, m_push;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ms = 0;
      m_addr = 0;
      mq.delete();
    end else begin
      m_pop = mq.size() != 0 && (mq[0].s ? st_ready : ld_ready);
      m_push = ms == 2 && wb_in_walk_mode && (wb_search_address_o[31:5] == m_addr[31:5]);
      m_nxt = ms;
      if (ms == 0 && refill_valid && mq.size() == 0) begin m_nxt = 1; m_addr = refill_addr; end
      if (ms == 1) m_nxt = wb_search_found_one ? 2 : 3;
      if (ms == 2 && wb_in_walk_mode && !wb_search_found_multi) m_nxt = 3;
      if (ms == 3 && mq.size() == 0) m_nxt = 0;
      ms = m_nxt;
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        m_e.s = wb_search_is_store; m_e.a = wb_search_address_o; m_e.d = wb_search_data;
        m_e.mo = wb_search_microop; m_e.de = wb_search_dest; m_e.tk = wb_search_ticket;
        mq.push_back(m_e);
      end
    end

  logic [31:0] ld_log[$], st_log[$];
  int inv_cnt = 0;
  bit e_ld, e_st;

  // per-cycle comparison against the model, plus transfer logging
  always @(negedge clk) begin
    e_ld = mq.size() != 0 && !mq[0].s;
    e_st = mq.size() != 0 && mq[0].s;
    check("m_ld_valid", ld_valid, e_ld);
    check("m_st_valid", st_valid, e_st);
    check("m_refill_ready", refill_ready, ms == 0 && mq.size() == 0);
    check("m_busy", busy, ms != 0 || mq.size() != 0);
    check("m_invalidate", wb_search_invalidate, ms == 1 && wb_search_found_one);
    check("m_search_addr", wb_search_address, (ms == 1 || ms == 2) ? m_addr : 32'h0);
    if (e_ld) begin
      check("m_ld_addr", ld_addr, mq[0].a);
      check("m_ld_data", ld_data, mq[0].d);
      check("m_ld_microop", ld_microop, mq[0].mo);
      check("m_ld_dest", ld_dest, mq[0].de);
      check("m_ld_ticket", ld_ticket, mq[0].tk);
    end
    if (e_st) begin
      check("m_st_addr", st_addr, mq[0].a);
      check("m_st_data", st_data, mq[0].d);
      check("m_st_microop", st_microop, mq[0].mo);
    end
    if (rst_n && ld_valid && ld_ready) ld_log.push_back(ld_addr);
    if (rst_n && st_valid && st_ready) st_log.push_back(st_addr);
    if (wb_search_invalidate) inv_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40 && !(refill_ready && !busy); i++) tick;
    check(name, {refill_ready, busy}, 2'b10);
  endtask

  task automatic refill(input logic [31:0] a, input bit one);
    refill_valid = 1; refill_addr = a; wb_search_found_one = one;
    tick;
    refill_valid = 0;
    check("lookup_invalidate", wb_search_invalidate, one);
    check("lookup_search_addr", wb_search_address, a);
    tick;
  endtask

  task automatic walk(input bit s, input logic [31:0] a, input bit m);
    wb_in_walk_mode = 1; wb_search_is_store = s; wb_search_address_o = a;
    wb_search_data = a ^ 32'hdead_0000; wb_search_microop = a[6:2];
    wb_search_dest = a[7:2]; wb_search_ticket = a[4:2]; wb_search_found_multi = m;
    tick;
    wb_in_walk_mode = 0;
  endtask

  task automatic clear_logs;
    ld_log.delete(); st_log.delete(); inv_cnt = 0;
  endtask

  initial begin
    tick; tick;
    check("rst_refill_ready", refill_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_ld_valid", ld_valid, 0);
    check("rst_st_valid", st_valid, 0);
    check("rst_search_addr", wb_search_address, 0);
    rst_n = 1;
    tick;

    // no match: LOOKUP, DRAIN, then IDLE
    clear_logs();
    refill(32'h1000, 0);
    check("t1_busy_drain", busy, 1);
    check("t1_ready_drain", refill_ready, 0);
    tick;
    check("t1_busy_idle", busy, 0);
    check("t1_ready_idle", refill_ready, 1);
    check("t1_inv_cnt", inv_cnt, 0);

    // three loads replayed in order
    clear_logs();
    ld_ready = 1;
    refill(32'h1000, 1);
    walk(0, 32'h1000, 1);
    check("t2_first_valid", ld_valid, 1);
    check("t2_first_addr", ld_addr, 32'h1000);
    walk(0, 32'h1004, 1);
    walk(0, 32'h1008, 0);
    wait_idle("t2_idle");
    check("t2_inv_cnt", inv_cnt, 1);
    check("t2_n_ld", ld_log.size(), 3);
    check("t2_ld0", ld_log[0], 32'h1000);
    check("t2_ld1", ld_log[1], 32'h1004);
    check("t2_ld2", ld_log[2], 32'h1008);

    // stalled store blocks the following load
    clear_logs();
    st_ready = 0;
    refill(32'h1000, 1);
    walk(1, 32'h1004, 1);
    check("t3_st_valid", st_valid, 1);
    walk(0, 32'h1004, 0);
    for (int i = 0; i < 3; i++) begin
      check("t3_stall_no_ld", ld_valid, 0);
      tick;
    end
    st_ready = 1;
    tick;
    check("t3_ld_after_st", ld_valid, 1);
    check("t3_ld_addr", ld_addr, 32'h1004);
    wait_idle("t3_idle");
    check("t3_n_st", st_log.size(), 1);
    check("t3_n_ld", ld_log.size(), 1);
    check("t3_st0", st_log[0], 32'h1004);

    // entry from another block is filtered out
    clear_logs();
    refill(32'h1000, 1);
    walk(0, 32'h1000, 1);
    walk(0, 32'h2000, 1);
    walk(0, 32'h101c, 0);
    wait_idle("t4_idle");
    check("t4_n_ld", ld_log.size(), 2);
    check("t4_ld0", ld_log[0], 32'h1000);
    check("t4_ld1", ld_log[1], 32'h101c);

    // reset in the middle of a walk
    clear_logs();
    ld_ready = 0;
    refill(32'h1000, 1);
    walk(0, 32'h1000, 1);
    walk(0, 32'h1004, 1);
    check("t5_pre_ld_valid", ld_valid, 1);
    check("t5_pre_busy", busy, 1);
    rst_n = 0;
    #1;
    check("t5_ld_valid", ld_valid, 0);
    check("t5_st_valid", st_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_refill_ready", refill_ready, 1);
    check("t5_search_addr", wb_search_address, 0);
    check("t5_invalidate", wb_search_invalidate, 0);
    tick;
    rst_n = 1;
    ld_ready = 1;
    tick;
    refill(32'h3000, 1);
    walk(0, 32'h3000, 0);
    wait_idle("t5_idle");
    check("t5_n_ld", ld_log.size(), 1);
    check("t5_ld0", ld_log[0], 32'h3000);

    // mixed loads and stores
    clear_logs();
    refill(32'h1000, 1);
    walk(0, 32'h1000, 1);
    walk(1, 32'h1004, 1);
    walk(0, 32'h1008, 1);
    walk(1, 32'h100c, 1);
    walk(0, 32'h1010, 0);
    wait_idle("t6_idle");
    check("t6_n_ld", ld_log.size(), 3);
    check("t6_n_st", st_log.size(), 2);
    check("t6_st1", st_log[1], 32'h100c);
    check("t6_ld2", ld_log[2], 32'h1010);
`ifdef WB_REPLAY_PERF_EN
    check("perf_ld_cnt", perf_ld_cnt, 4);
    check("perf_st_cnt", perf_st_cnt, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
